// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte streams.
// A grant is held for a whole packet; bytes pass through a one-entry holding register.
module uart_tx_arb #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_en_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             uart_data_o,
  output logic                   uart_valid_o,
  input  logic                   uart_ready_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = (MAX_BURST > 0) ? BW'(MAX_BURST - 1) : '0;
  localparam logic [TW-1:0] IDLE_MAX   = TW'(IDLE_TIMEOUT);
  localparam logic [TW-1:0] IDLE_LAST  = (IDLE_TIMEOUT > 0) ? TW'(IDLE_TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t             state_reg;
  logic [IW-1:0]      rr_ptr_reg;
  logic [IW-1:0]      gnt_idx_reg;
  logic [NUM_REQ-1:0] grant_reg;
  logic [BW-1:0]      burst_cnt_reg;
  logic [TW-1:0]      idle_cnt_reg;
  logic [7:0]         data_reg;
  logic               valid_reg;

  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      cand_idx;
  logic               sel_found;
  logic               accept;
  logic [7:0]         cur_data;
  logic               cur_last;

  // Search starts just after the last served requester so every stream gets a turn.
  always_comb begin
    sel_idx   = '0;
    cand_idx  = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IW'((int'(rr_ptr_reg) + k) % NUM_REQ);
      if (!sel_found && req_valid_i[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready_o[gi] = (state_reg == GRANT) && grant_reg[gi] && cfg_en_i && !valid_reg;
  end

  assign accept   = |(req_valid_i & req_ready_o);
  assign cur_data = req_data_i[{gnt_idx_reg, 3'b000} +: 8];
  assign cur_last = req_last_i[gnt_idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= IW'(NUM_REQ - 1);
      gnt_idx_reg   <= '0;
      grant_reg     <= '0;
      burst_cnt_reg <= '0;
      idle_cnt_reg  <= '0;
      data_reg      <= 8'hFF;
      valid_reg     <= 1'b0;
    end else if (!cfg_en_i) begin
      // Disable aborts the packet and drops any pending byte; rr_ptr survives.
      state_reg <= IDLE;
      grant_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (valid_reg && uart_ready_i) begin
        valid_reg <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            gnt_idx_reg   <= sel_idx;
            grant_reg     <= NUM_REQ'(1) << sel_idx;
            burst_cnt_reg <= '0;
            idle_cnt_reg  <= '0;
            state_reg     <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            data_reg     <= cur_data;
            valid_reg    <= 1'b1;
            idle_cnt_reg <= '0;
            if (burst_cnt_reg != BURST_MAX) begin
              burst_cnt_reg <= burst_cnt_reg + 1'b1;
            end
            if (cur_last || (MAX_BURST != 0 && burst_cnt_reg == BURST_LAST)) begin
              state_reg <= DRAIN;
            end
          end else if (!req_valid_i[gnt_idx_reg]) begin
            if (idle_cnt_reg != IDLE_MAX) begin
              idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
            if (IDLE_TIMEOUT != 0 && idle_cnt_reg == IDLE_LAST) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!valid_reg) begin
            rr_ptr_reg <= gnt_idx_reg;
            grant_reg  <= '0;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign uart_data_o  = data_reg;
  assign uart_valid_o = valid_reg;
  assign grant_o      = grant_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares the single UART transmitter between NUM_REQ byte-stream requesters.
- Grants one requester at a time and locks the grant for a whole packet (until last, the burst limit, or an idle timeout).
- Buffers one byte in a holding register that drives the transmitter's data/valid inputs and drains on the transmitter's ready.
- Sits between peripheral/debug byte sources and the UART transmit datapath.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- MAX_BURST, 16: maximum bytes per grant before forced rotation; 0 = unlimited.
- IDLE_TIMEOUT, 255: cycles a granted requester may hold req_valid low before the grant is released; 0 = never release.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cfg_en_i  input  1  UART enable; low aborts and holds block in IDLE.
- req_valid_i  input  NUM_REQ  per-requester byte valid.
- req_data_i  input  8*NUM_REQ  per-requester byte; requester i on bits [8i+7:8i].
- req_last_i  input  NUM_REQ  byte is last of packet.
- req_ready_o  output  NUM_REQ  per-requester accept.
- uart_data_o  output  8  byte to transmitter.
- uart_valid_o  output  1  holding register full.
- uart_ready_i  input  1  transmitter ready (idle and enabled).
- grant_o  output  NUM_REQ  one-hot current grant; 0 when none.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, grant_o 0, uart_valid_o 0, uart_data_o 8'hFF, busy_o 0, rr_ptr NUM_REQ-1 (requester 0 wins first), burst_cnt 0, idle_cnt 0.
- States:
  - IDLE: if cfg_en_i and any req_valid_i, select the first valid index searching from rr_ptr+1 mod NUM_REQ upward. Register grant_o to that index, clear burst_cnt and idle_cnt, go to GRANT. Arbitration takes 1 cycle.
  - GRANT: req_ready_o[g] = cfg_en_i & !uart_valid_o; all other ready bits 0.
    - On accept (valid & ready at granted index): uart_data_o <= data, uart_valid_o <= 1, burst_cnt++, idle_cnt <= 0.
    - If the accepted byte has last=1, or burst_cnt+1 == MAX_BURST (MAX_BURST != 0), go to DRAIN.
    - When req_valid_i[g] is low: idle_cnt++. On reaching IDLE_TIMEOUT (nonzero), go to DRAIN.
  - DRAIN: no ready asserted. When uart_valid_o == 0, set rr_ptr <= g, clear grant_o, go to IDLE.
- Holding register:
  - uart_valid_o clears on uart_valid_o & uart_ready_i in any state.
  - Data is held stable while valid and not ready.
  - A new byte is accepted only when the register is empty, so there is no same-cycle load and drain.
- Latency: req_valid in IDLE at cycle 0 -> grant_o and req_ready_o at cycle 1 -> uart_valid_o at cycle 2.
- Lock: non-granted requesters are never served mid-packet, even if the granted requester pauses (up to IDLE_TIMEOUT).
- cfg_en_i low in any state: next cycle state IDLE, grant_o 0, uart_valid_o 0 (pending byte dropped). rr_ptr is retained. Ready outputs drop combinationally.
- rst_n asserted mid-packet: all registers return to reset values immediately. The partial packet is lost.
- Counter widths: burst_cnt and idle_cnt are wide enough for MAX_BURST and IDLE_TIMEOUT respectively; they saturate and do not wrap.
- Simultaneous requests in IDLE: the round-robin order decides. Requests arriving in GRANT/DRAIN wait.

Test Plan:
- Requester 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), uart_ready_i pulses one cycle every 20 cycles -> uart_data_o sequence 41,42,43, each held until accepted; grant_o=0001 throughout; busy_o falls 1 cycle after the final drain.
- All 4 requesters valid continuously, 1-byte packets (last=1) -> grant order 0,1,2,3,0; never two bytes from the same requester consecutively.
- Requester 2 streams 20 bytes without last, MAX_BURST=16, requester 1 also valid -> after byte 16, grant moves to requester 3 if valid, else 0, then 1 (not 2); requester 2 resumes on a later round.
- Requester 1 sends 1 byte with last=0, then drops valid; IDLE_TIMEOUT=8 -> grant released 8 cycles later after the drain; waiting requester 3 granted next.
- cfg_en_i deasserted while uart_valid_o=1 with byte 0x55 -> next cycle uart_valid_o=0, grant_o=0, state IDLE; after re-enable, arbitration resumes from the retained rr_ptr.
- rst_n pulsed low asynchronously mid-packet -> outputs go to reset values without a clock edge; first grant after release goes to requester 0.
